// File: rtl/pe_pkg.sv
// Shared definitions for the weight-stationary PE: mode encoding and a
// width-parametrised signed saturating adder.
package pe_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_IDLE    = 2'b00;
  localparam mode_t MODE_LOAD    = 2'b01;
  localparam mode_t MODE_COMPUTE = 2'b10;

  localparam int SAT_MAX_W = 64;

  // Operands arrive sign-extended to SAT_MAX_W; the result is clamped to the
  // signed range of a w-bit word (w <= SAT_MAX_W).
  function automatic logic signed [SAT_MAX_W-1:0] sat_add(
    input logic signed [SAT_MAX_W-1:0] a,
    input logic signed [SAT_MAX_W-1:0] b,
    input int                          w
  );
    logic signed [SAT_MAX_W:0] sum;
    logic signed [SAT_MAX_W:0] one;
    logic signed [SAT_MAX_W:0] hi;
    logic signed [SAT_MAX_W:0] lo;
    one = (SAT_MAX_W+1)'(1);
    sum = {a[SAT_MAX_W-1], a} + {b[SAT_MAX_W-1], b};
    hi  = (one <<< (w - 1)) - one;
    lo  = -(one <<< (w - 1));
    if (sum > hi)
      return hi[SAT_MAX_W-1:0];
    else if (sum < lo)
      return lo[SAT_MAX_W-1:0];
    else
      return sum[SAT_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/pe_ws_dbuf_if.sv
// Neighbour-port bundle of the weight-stationary PE. The master side drives
// the i_* signals, the PE (slave) drives the o_* signals.
interface pe_ws_dbuf_if
  import pe_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
);
  mode_t                     i_mode;
  logic                      i_top_valid;
  logic signed [ACC_W-1:0]   i_top;
  logic                      i_left_valid;
  logic signed [DATA_W-1:0]  i_left;
  logic                      i_swap;
  logic                      o_bot_valid;
  logic signed [ACC_W-1:0]   o_bot;
  logic                      o_right_valid;
  logic signed [DATA_W-1:0]  o_right;
  logic                      o_swap;
  logic                      o_shadow_full;

  modport master (
    output i_mode, i_top_valid, i_top, i_left_valid, i_left, i_swap,
    input  o_bot_valid, o_bot, o_right_valid, o_right, o_swap, o_shadow_full
  );

  modport slave (
    input  i_mode, i_top_valid, i_top, i_left_valid, i_left, i_swap,
    output o_bot_valid, o_bot, o_right_valid, o_right, o_swap, o_shadow_full
  );
endinterface

// File: rtl/pe_mac.sv
// Combinational signed MAC: psum + act*weight at full product width.
// Build option: define PE_SAT_EN to saturate the addition instead of wrapping.
module pe_mac
  import pe_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
) (
  input  logic signed [DATA_W-1:0] act,
  input  logic signed [DATA_W-1:0] weight,
  input  logic signed [ACC_W-1:0]  psum,
  output logic signed [ACC_W-1:0]  sum
);
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;

  assign prod     = act * weight;
  assign prod_ext = ACC_W'(prod);

`ifdef PE_SAT_EN
  assign sum = ACC_W'(sat_add(SAT_MAX_W'(psum), SAT_MAX_W'(prod_ext), ACC_W));
`else
  assign sum = psum + prod_ext;
`endif

endmodule

// File: rtl/pe_ws_dbuf.sv
// Weight-stationary systolic PE with shadow/active weight double buffer and
// a forwarded swap token. Build option: PE_SAT_EN (saturating accumulate).
module pe_ws_dbuf
  import pe_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
) (
  input logic         clk,
  input logic         rst,
  pe_ws_dbuf_if.slave bus
);
  logic signed [DATA_W-1:0] active_p0;
  logic signed [DATA_W-1:0] shadow_p0;
  logic                     shadow_full_p0;
  logic signed [ACC_W-1:0]  bot_p0;
  logic                     vld_bot_p0;
  logic signed [DATA_W-1:0] right_p0;
  logic                     vld_right_p0;
  logic                     swap_p0;

  logic signed [ACC_W-1:0]  psum_in;
  logic signed [ACC_W-1:0]  mac_sum;

  // Missing top valid means this is the first row: start from a zero psum.
  assign psum_in = bus.i_top_valid ? bus.i_top : '0;

  pe_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .act    (bus.i_left),
    .weight (active_p0),
    .psum   (psum_in),
    .sum    (mac_sum)
  );

  // Input -> output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      active_p0      <= '0;
      shadow_p0      <= '0;
      shadow_full_p0 <= 1'b0;
      bot_p0         <= '0;
      vld_bot_p0     <= 1'b0;
      right_p0       <= '0;
      vld_right_p0   <= 1'b0;
      swap_p0        <= 1'b0;
    end else begin
      right_p0     <= bus.i_left;
      vld_right_p0 <= bus.i_left_valid;
      swap_p0      <= bus.i_swap;
      vld_bot_p0   <= 1'b0;

      // A load in the same cycle overrides the flag clear below.
      if (bus.i_swap && shadow_full_p0) begin
        active_p0      <= shadow_p0;
        shadow_full_p0 <= 1'b0;
      end

      case (bus.i_mode)
        MODE_LOAD: begin
          if (bus.i_top_valid) begin
            shadow_p0      <= bus.i_top[DATA_W-1:0];
            shadow_full_p0 <= 1'b1;
            bot_p0         <= {{(ACC_W-DATA_W){1'b0}}, shadow_p0};
            vld_bot_p0     <= 1'b1;
          end
        end
        MODE_COMPUTE: begin
          if (bus.i_left_valid) begin
            bot_p0     <= mac_sum;
            vld_bot_p0 <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.o_bot_valid   = vld_bot_p0;
  assign bus.o_bot         = bot_p0;
  assign bus.o_right_valid = vld_right_p0;
  assign bus.o_right       = right_p0;
  assign bus.o_swap        = swap_p0;
  assign bus.o_shadow_full = shadow_full_p0;

endmodule

// File: tb/tb_pe_ws_dbuf.sv
// Directed bench for pe_ws_dbuf: reset, vector table, and reset mid-stream.
module tb_pe_ws_dbuf;
  localparam int DATA_W = 16;
  localparam int ACC_W  = 32;

`ifdef PE_SAT_EN
  localparam logic [31:0] OVF_POS = 32'h7FFF_FFFF;
  localparam logic [31:0] OVF_NEG = 32'h8000_0000;
`else
  localparam logic [31:0] OVF_POS = 32'h8000_0000;
  localparam logic [31:0] OVF_NEG = 32'h7FFF_FFF0;
`endif

  typedef struct {
    logic [1:0]  mode;
    logic        tv;
    logic [31:0] top;
    logic        lv;
    logic [15:0] left;
    logic        swap;
    logic        ebv;
    logic [31:0] ebot;
    logic        efull;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  vec_t vecs[$];

  pe_ws_dbuf_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

  pe_ws_dbuf #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] m, input logic tv, input logic [31:0] top,
                     input logic lv, input logic [15:0] left, input logic sw,
                     input logic ebv, input logic [31:0] ebot, input logic efull);
    vec_t v;
    v.mode = m; v.tv = tv; v.top = top; v.lv = lv; v.left = left; v.swap = sw;
    v.ebv = ebv; v.ebot = ebot; v.efull = efull;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [1:0] m, input logic tv, input logic [31:0] top,
                       input logic lv, input logic [15:0] left, input logic sw);
    bus.i_mode       = m;
    bus.i_top_valid  = tv;
    bus.i_top        = top;
    bus.i_left_valid = lv;
    bus.i_left       = left;
    bus.i_swap       = sw;
  endtask

  task automatic check_all(input string tag, input logic ebv, input logic [31:0] ebot,
                           input logic erv, input logic [15:0] eright,
                           input logic esw, input logic efull);
    check({tag, ".bot_valid"},   32'(bus.o_bot_valid),   32'(ebv));
    check({tag, ".bot"},         bus.o_bot,              ebot);
    check({tag, ".right_valid"}, 32'(bus.o_right_valid), 32'(erv));
    check({tag, ".right"},       {16'h0, bus.o_right},   {16'h0, eright});
    check({tag, ".swap"},        32'(bus.o_swap),        32'(esw));
    check({tag, ".full"},        32'(bus.o_shadow_full), 32'(efull));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    //   mode  tv  top            lv  left      sw   ebv ebot          efull
    add(2'd1, 1, 32'd5,          0, 16'd0,    0,   1, 32'd0,         1); // 0 load 5
    add(2'd1, 1, 32'd7,          0, 16'd0,    0,   1, 32'd5,         1); // 1 load 7
    add(2'd0, 0, 32'd0,          0, 16'd0,    1,   0, 32'd5,         0); // 2 swap -> active 7
    add(2'd2, 0, 32'd0,          1, 16'd3,    0,   1, 32'd21,        0); // 3 3*7
    add(2'd0, 0, 32'd0,          0, 16'd0,    1,   0, 32'd21,        0); // 4 swap, shadow empty
    add(2'd2, 0, 32'd0,          1, 16'd2,    0,   1, 32'd14,        0); // 5 active still 7
    add(2'd1, 1, 32'd11,         0, 16'd0,    0,   1, 32'd7,         1); // 6 load 11
    add(2'd1, 1, 32'd9,          0, 16'd0,    1,   1, 32'd11,        1); // 7 swap + load 9
    add(2'd2, 0, 32'd0,          1, 16'd1,    0,   1, 32'd11,        1); // 8 active = 11
    add(2'd0, 0, 32'd0,          0, 16'd0,    1,   0, 32'd11,        0); // 9 swap -> active 9
    add(2'd2, 0, 32'd0,          1, 16'hFFFF, 0,   1, 32'hFFFF_FFF7, 0); // 10 -1*9
    add(2'd1, 1, 32'd2,          0, 16'd0,    0,   1, 32'd9,         1); // 11 load 2
    add(2'd0, 0, 32'd0,          0, 16'd0,    1,   0, 32'd9,         0); // 12 active 2
    add(2'd1, 1, 32'h0000_FFFC,  0, 16'd0,    0,   1, 32'd2,         1); // 13 shadow -4
    add(2'd2, 1, 32'd100,        1, 16'd10,   1,   1, 32'd120,       0); // 14 old active 2
    add(2'd2, 1, 32'd100,        1, 16'd10,   0,   1, 32'd60,        0); // 15 active -4
    add(2'd2, 1, 32'd100,        0, 16'd10,   0,   0, 32'd60,        0); // 16 gap: hold
    add(2'd2, 1, 32'd0,          1, 16'd1,    0,   1, 32'hFFFF_FFFC, 0); // 17 -4
    add(2'd1, 1, 32'd1,          0, 16'd0,    0,   1, 32'h0000_FFFC, 1); // 18 zero-ext
    add(2'd0, 0, 32'd0,          0, 16'd0,    1,   0, 32'h0000_FFFC, 0); // 19 active 1
    add(2'd2, 1, 32'h7FFF_FFF0,  1, 16'd16,   0,   1, OVF_POS,       0); // 20 +ovf
    add(2'd2, 1, 32'h8000_0000,  1, 16'hFFF0, 0,   1, OVF_NEG,       0); // 21 -ovf
    add(2'd3, 1, 32'd50,         1, 16'd5,    0,   0, OVF_NEG,       0); // 22 reserved

    // Reset with random inputs
    rst = 1'b1;
    drive(2'($urandom), 1'($urandom), $urandom, 1'($urandom), 16'($urandom), 1'($urandom));
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check_all($sformatf("reset%0d", i), 0, 32'd0, 0, 16'd0, 0, 0);
      drive(2'($urandom), 1'($urandom), $urandom, 1'($urandom), 16'($urandom), 1'($urandom));
    end
    rst = 1'b0;
    drive(2'd0, 0, 32'd0, 0, 16'd0, 0);

    // Vector table
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].mode, vecs[i].tv, vecs[i].top, vecs[i].lv, vecs[i].left, vecs[i].swap);
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].ebv, vecs[i].ebot,
                vecs[i].lv, vecs[i].left, vecs[i].swap, vecs[i].efull);
    end

    // Reset mid-compute: no valid pulse, all state cleared
    drive(2'd1, 1, 32'd33, 0, 16'd0, 0);
    @(posedge clk);
    #1;
    check("pre_rst.full", 32'(bus.o_shadow_full), 32'd1);
    drive(2'd2, 1, 32'd50, 1, 16'd7, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all("midrst", 0, 32'd0, 0, 16'd0, 0, 0);
    rst = 1'b0;
    // Active weight cleared to 0: output equals the incoming psum
    drive(2'd2, 1, 32'd3, 1, 16'd5, 0);
    @(posedge clk);
    #1;
    check_all("post_rst", 1, 32'd3, 1, 16'd5, 0, 0);
    // Shadow also cleared: a swap promotes nothing
    drive(2'd0, 0, 32'd0, 0, 16'd0, 1);
    @(posedge clk);
    #1;
    drive(2'd2, 0, 32'd0, 1, 16'd9, 0);
    @(posedge clk);
    #1;
    check_all("post_rst_swap", 1, 32'd0, 1, 16'd9, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
